// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: instruction-fetch front end with PC register, a
// 1-cycle-latency instruction memory request port, a 2-entry skid buffer
// that holds responses returning while ID is frozen, and the IF/ID register.
// Optional build macro: FETCH_STALL_PERF_EN adds a saturating stall counter
// on stall_count_op; without it the output is tied to 0 and no flops exist.
//
// Handshake: imem_req_op is a one-cycle request with imem_addr_op; the memory
// answers on imem_rdata_ip exactly one cycle later, unconditionally. There is
// no backpressure on the memory side, so requests are only issued when the
// skid buffer is guaranteed to have room for the answer (occupancy < 2) or
// when ID is free to drain it in the answering cycle.
module fetch_hold_buffer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_ip,
   input  logic        flush_ip,
   input  logic [31:0] flush_target_ip,
   output logic        imem_req_op,
   output logic [31:0] imem_addr_op,
   input  logic [31:0] imem_rdata_ip,
   output logic [31:0] ID_instr_op,
   output logic [31:0] ID_pc_op,
   output logic        ID_valid_op,
   output logic        EX_bubble_op,
   output logic [31:0] stall_count_op
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   logic [31:0] pc_q;
   logic        inflight_q;
   logic [31:0] inflight_pc_q;
   logic        kill_q;

   logic [31:0] buf_pc_q    [2];
   logic [31:0] buf_instr_q [2];
   logic        rd_ptr_q;
   logic        wr_ptr_q;
   logic [1:0]  buf_cnt_q;

   logic [1:0]  occ;
   logic        buf_empty;
   logic        rsp_valid;
   logic        issue;
   logic        push;
   logic        pop;

   // flush_target_ip[1:0] carries no information: fetch is word aligned
   logic        unused_target_lsbs;
   assign unused_target_lsbs = ^flush_target_ip[1:0];

   // Occupancy bookkeeping, issue decision and skid buffer push/pop control
   always_comb begin
      occ          = buf_cnt_q + {1'b0, inflight_q};
      buf_empty    = (buf_cnt_q == 2'd0);
      rsp_valid    = inflight_q & ~kill_q;
      issue        = reset & ~flush_ip & ((occ < 2'd2) | ~stall_ip);
      // ID drains the buffer head first; a response goes straight to ID
      // only when the buffer is empty and ID is running
      pop          = ~stall_ip & ~flush_ip & ~buf_empty;
      push         = rsp_valid & ~flush_ip & (stall_ip | ~buf_empty);
      imem_req_op  = issue;
      imem_addr_op = pc_q;
      EX_bubble_op = reset & stall_ip & ~flush_ip;
   end

   // PC, in-flight tracking and response kill flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC_ALIGNED;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'd0;
         kill_q        <= 1'b0;
      end else begin
         if (flush_ip)
            pc_q <= {flush_target_ip[31:2], 2'b00};
         else if (issue)
            pc_q <= pc_q + 32'd4;
         inflight_q <= issue;
         if (issue)
            inflight_pc_q <= pc_q;
         kill_q <= flush_ip & inflight_q;
      end
   end

   // Skid buffer pointers and count; a flush empties the buffer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         buf_cnt_q <= 2'd0;
      end else if (flush_ip) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         buf_cnt_q <= 2'd0;
      end else begin
         if (push)
            wr_ptr_q <= ~wr_ptr_q;
         if (pop)
            rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
            default: buf_cnt_q <= buf_cnt_q;
         endcase
      end
   end

   // Skid buffer storage; contents are meaningless until counted valid
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
         buf_instr_q[wr_ptr_q] <= imem_rdata_ip;
      end
   end

   // IF/ID register: flush clears, stall holds, otherwise buffer head,
   // then the fresh response, then a bubble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ID_valid_op <= 1'b0;
         ID_instr_op <= NOP_INSTR;
         ID_pc_op    <= 32'd0;
      end else if (flush_ip) begin
         ID_valid_op <= 1'b0;
         ID_instr_op <= NOP_INSTR;
      end else if (!stall_ip) begin
         if (!buf_empty) begin
            ID_valid_op <= 1'b1;
            ID_instr_op <= buf_instr_q[rd_ptr_q];
            ID_pc_op    <= buf_pc_q[rd_ptr_q];
         end else if (rsp_valid) begin
            ID_valid_op <= 1'b1;
            ID_instr_op <= imem_rdata_ip;
            ID_pc_op    <= inflight_pc_q;
         end else begin
            ID_valid_op <= 1'b0;
            ID_instr_op <= NOP_INSTR;
         end
      end
   end

`ifdef FETCH_STALL_PERF_EN
   logic [31:0] stall_count_q;

   // Saturating count of cycles in which EX receives a stall bubble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_count_q <= 32'd0;
      else if (stall_ip && !flush_ip && stall_count_q != 32'hFFFF_FFFF)
         stall_count_q <= stall_count_q + 32'd1;
   end

   assign stall_count_op = stall_count_q;
`else
   assign stall_count_op = 32'd0;
`endif

`ifndef SYNTHESIS
   // Issue throttling must keep occupancy at or below two entries
   always_ff @(posedge clk) begin
      if (reset)
         assert (!(push && buf_cnt_q == 2'd2 && !pop));
   end
`endif

endmodule

// File: doc/fetch_hold_buffer.md
# fetch_hold_buffer

Instruction-fetch front end that consumes the pipeline's `stall_op` and flush signals, the receiving end of the hazard/stall interface. It owns the PC register and issues requests to a 1-cycle-latency synchronous instruction memory. A 2-entry skid buffer captures responses that return while ID is frozen, so no fetched instruction is lost or duplicated. It drives the IF/ID pipeline register (`ID_instr_op`, `ID_pc_op`, `ID_valid_op`) and the bubble request into ID/EX.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: `addi x0,x0,0`, driven on `ID_instr_op` whenever ID is invalid.
- `clk`, input, 1: the single clock; all state on rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `stall_ip`, input, 1: from the stall controller; freeze ID and insert a bubble into EX.
- `flush_ip`, input, 1: taken branch or jump; redirect fetch.
- `flush_target_ip`, input, 32: redirect address; bits [1:0] ignored.
- `imem_req_op`, output, 1: fetch request this cycle.
- `imem_addr_op`, output, 32: fetch address; [1:0] always 0.
- `imem_rdata_ip`, input, 32: instruction for the request issued the previous cycle.
- `ID_instr_op`, output, 32: IF/ID instruction register.
- `ID_pc_op`, output, 32: IF/ID PC register.
- `ID_valid_op`, output, 1: IF/ID holds a real instruction.
- `EX_bubble_op`, output, 1: combinational `stall_ip & ~flush_ip`; ID/EX loads a NOP.
- `stall_count_op`, output, 32: stall performance counter (see Configuration).

## Operation
- **State.**
  - `pc_q`: next fetch address.
  - `inflight_q`: request issued last cycle; `inflight_pc_q` holds its address.
  - `kill_q`: that response is to be discarded.
  - Buffer: 2-entry FIFO of {pc, instr} with `buf_cnt` from 0 to 2.
  - Occupancy `occ = buf_cnt + inflight_q`. Invariant: `occ <= 2`.
- **Issue rule.** `imem_req_op = ~flush_ip & (occ < 2 | ~stall_ip)`. On issue: `imem_addr_op = pc_q`, then `pc_q += 4`, `inflight_q <= 1`, `inflight_pc_q <= pc_q`.
- **Response.** A response is valid when `inflight_q & ~kill_q`.
- **ID update when `~stall_ip & ~flush_ip`.** ID loads from the first available source:
  1. Buffer head (pop).
  2. The valid response.
  3. Nothing: `ID_valid_op <= 0`, `ID_instr_op <= NOP_INSTR`.
  - A valid response not consumed by ID is pushed into the buffer.
- **ID update when `stall_ip & ~flush_ip`.**
  - ID holds, including when it holds an invalid NOP.
  - A valid response is pushed into the buffer.
- **Flush (`flush_ip=1`).** Flush has priority over stall.
  - ID gets NOP with valid 0.
  - The buffer is cleared.
  - `kill_q <= inflight_q`.
  - `pc_q <= {flush_target_ip[31:2], 2'b00}`.
  - No request is issued in the flush cycle.
- **Push into a full buffer** is impossible by the invariant. The simulation assertion fires on `push & buf_cnt==2 & ~pop`.
- **Reset (asynchronous, any time).** All of the following are forced regardless of outstanding requests; any in-flight response is ignored:
  - `pc_q = RESET_PC`
  - `inflight_q = 0`, `kill_q = 0`, `buf_cnt = 0`
  - `ID_valid_op = 0`, `ID_instr_op = NOP_INSTR`, `ID_pc_op = 0`
  - `stall_count_op = 0`
- **Reset values of combinational outputs.** During reset, `imem_req_op` and `EX_bubble_op` are 0.

## Timing
- **After reset release.**
  - Cycle 0: request `RESET_PC`.
  - Cycle 1: data returns.
  - Cycle 2: `ID_valid_op=1`, `ID_pc_op=RESET_PC`.
  - Steady state without stalls: one instruction per cycle; the buffer stays empty.
- **Flush penalty.** Flush in cycle t:
  - Cycle t+1: request to the target.
  - Cycle t+3: target is in ID.
  - ID is invalid in cycles t+1 and t+2.
- **Stall behaviour.**
  - A stall of N cycles holds ID for exactly N cycles.
  - At most 2 responses are buffered during the stall.
  - The first cycle after the stall drops, ID takes the oldest buffered instruction, with no gap.
- **Simultaneous stall and flush.** Treated as flush, and `EX_bubble_op=0`.

## Configuration
- `FETCH_STALL_PERF_EN` defined:
  - `stall_count_op` increments each cycle with `stall_ip & ~flush_ip`.
  - It saturates at 32'hFFFF_FFFF and clears only on reset.
- Not defined:
  - `stall_count_op` is tied to 0.
  - No counter flops exist.

## Test plan
- Reset release with `RESET_PC`=0x100 and no stalls -> requests 0x100, 0x104, 0x108 in cycles 0, 1, 2; ID shows 0x100 valid in cycle 2, then +4 per cycle.
- 1-cycle load-use stall with ID holding 0x108 -> ID holds 0x108 for 1 cycle, `EX_bubble_op`=1 for that cycle; then 0x10C, 0x110 follow with no gap or duplicate.
- 5-cycle stall -> requests stop once `occ`=2; `buf_cnt` peaks at 2; after release ID sequence is contiguous; the assertion never fires.
- Flush to 0x2002 with a request in flight and 2 buffered entries -> in-flight data is discarded; ID invalid for 2 cycles; ID=0x2000 valid in cycle t+3.
- Stall and flush asserted together -> flush behaviour, `EX_bubble_op`=0, and the counter does not increment.
- Reset asserted mid-stall with a full buffer -> all state returns to reset values immediately; with `FETCH_STALL_PERF_EN` the counter reads 0; a 7-cycle stall reads 7.
